// File: rtl/shiftreg_rx.sv
// Serial-load receiver for the dynamic and static configuration shift registers.
// Define SHIFTREG_RX_MISO_EN to add the MISO readback of the previous word.
module shiftreg_rx #(
  parameter int SIZESRDYN      = 16,
  parameter int SIZESRSTAT     = 88,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCLK,
  input  logic                  SEL,
  input  logic                  MOSI,
  output logic [SIZESRDYN-1:0]  DYN_Q,
  output logic [SIZESRSTAT-1:0] STAT_Q,
  output logic                  DYN_VLD,
  output logic                  STAT_VLD,
  output logic                  FRAME_ERR,
  output logic                  BUSY
`ifdef SHIFTREG_RX_MISO_EN
  ,
  output logic                  MISO
`endif
);

  // state   | meaning
  // IDLE    | no frame open, waiting for the first SCLK rise
  // RX_DYN  | dynamic frame open (SEL=0)
  // RX_STAT | static frame open (SEL=1)
  typedef enum logic [1:0] {IDLE, RX_DYN, RX_STAT} state_t;

  localparam int MAXW = (SIZESRDYN > SIZESRSTAT) ? SIZESRDYN : SIZESRSTAT;
  localparam int SW   = MAXW - 1;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, sel_sync, mosi_sync;
  logic sclk_s, sel_s, mosi_s, sclk_d, rise;
  logic [SW-1:0] shadow;
  logic [CW-1:0] bit_cnt, frame_len;
  logic [TW-1:0] idle_cnt;
  logic do_open, do_shift, do_done, do_abort;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync <= '0;
      sel_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], SEL};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sel_s  = sel_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign BUSY   = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // SEL change beats a same-cycle rise; a rise beats the timeout.
  always_comb begin
    state_nxt = state;
    do_open   = 1'b0;
    do_shift  = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    frame_len = (state == RX_STAT) ? CW'(SIZESRSTAT) : CW'(SIZESRDYN);
    case (state)
      IDLE: begin
        if (rise) begin
          do_open   = 1'b1;
          state_nxt = sel_s ? RX_STAT : RX_DYN;
        end
      end
      RX_DYN, RX_STAT: begin
        if (sel_s != (state == RX_STAT)) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else if (rise) begin
          if (bit_cnt == frame_len - CW'(1)) begin
            do_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            do_shift  = 1'b1;
          end
        end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow    <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      DYN_Q     <= '0;
      STAT_Q    <= '0;
      DYN_VLD   <= 1'b0;
      STAT_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      DYN_VLD   <= 1'b0;
      STAT_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (do_open) begin
        shadow   <= SW'(mosi_s);
        bit_cnt  <= CW'(1);
        idle_cnt <= '0;
      end else if (do_shift) begin
        shadow   <= SW'({shadow, mosi_s});
        bit_cnt  <= bit_cnt + CW'(1);
        idle_cnt <= '0;
      end else if (do_done) begin
        if (state == RX_DYN) begin
          DYN_Q   <= {shadow[SIZESRDYN-2:0], mosi_s};
          DYN_VLD <= 1'b1;
        end else begin
          STAT_Q   <= {shadow[SIZESRSTAT-2:0], mosi_s};
          STAT_VLD <= 1'b1;
        end
        shadow   <= '0;
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else if (do_abort) begin
        FRAME_ERR <= 1'b1;
        shadow    <= '0;
        bit_cnt   <= '0;
        idle_cnt  <= '0;
      end else if (state != IDLE) begin
        idle_cnt <= idle_cnt + TW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

`ifdef SHIFTREG_RX_MISO_EN
  // Readback is left-aligned so the MSB of either word sits on MISO; it keeps
  // shifting after completion so the last bit is still there at the final fall.
  localparam int RBW = MAXW;
  logic [RBW-1:0] rb;
  logic fall;

  assign fall = ~sclk_s & sclk_d;
  assign MISO = rb[RBW-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rb <= '0;
    end else if (do_open) begin
      rb <= sel_s ? (RBW'(STAT_Q) << (RBW - SIZESRSTAT))
                  : (RBW'(DYN_Q) << (RBW - SIZESRDYN));
    end else if (do_abort) begin
      rb <= '0;
    end else if (fall) begin
      rb <= {rb[RBW-2:0], 1'b0};
    end
  end
`endif

endmodule
